// File: rtl/cpm_pkg.sv
// Shared CPM packet types and field widths.
// Imported by the arbiter, its stream interface and the testbench.
package cpm_pkg;

  localparam int CPM_ID_W      = 4;
  localparam int CPM_OPC_W     = 4;
  localparam int CPM_PAYLOAD_W = 16;

  typedef struct packed {
    logic [CPM_ID_W-1:0]      id;
    logic [CPM_OPC_W-1:0]     opcode;
    logic [CPM_PAYLOAD_W-1:0] payload;
  } cpm_pkt_t;

endpackage

// File: rtl/cpm_in_arbiter_if.sv
// CPM input stream: valid/ready handshake plus packet fields.
// The master drives the packet; the slave returns ready.
interface cpm_stream_if #(
  parameter int SRC_W = 2
);
  import cpm_pkg::*;

  logic                     out_valid;
  logic                     out_ready;
  logic [CPM_ID_W-1:0]      out_id;
  logic [CPM_OPC_W-1:0]     out_opcode;
  logic [CPM_PAYLOAD_W-1:0] out_payload;
  logic [SRC_W-1:0]         out_src;

  modport master (
    output out_valid,
    output out_id,
    output out_opcode,
    output out_payload,
    output out_src,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_id,
    input  out_opcode,
    input  out_payload,
    input  out_src,
    output out_ready
  );

endinterface

// File: rtl/cpm_in_arbiter_rr_picker.sv
// Round-robin priority select: first eligible port at or
// after ptr, wrapping. Purely combinational.
module cpm_rr_picker #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] eligible,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx,
  output logic         any
);

  logic [W-1:0] p;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    p     = '0;
    for (int k = 0; k < N; k++) begin
      p = W'((int'(ptr) + k) % N);
      if (!any && eligible[p]) begin
        any      = 1'b1;
        grant[p] = 1'b1;
        idx      = p;
      end
    end
  end

endmodule

// File: rtl/cpm_in_arbiter.sv
// N-port round-robin arbiter feeding one registered CPM
// input stream; counts accepted packets per port.
module cpm_in_arbiter
  import cpm_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int CNT_W     = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_PORTS-1:0]               req_valid,
  output logic [NUM_PORTS-1:0]               req_ready,
  input  logic [NUM_PORTS*CPM_ID_W-1:0]      req_id,
  input  logic [NUM_PORTS*CPM_OPC_W-1:0]     req_opcode,
  input  logic [NUM_PORTS*CPM_PAYLOAD_W-1:0] req_payload,
  input  logic [NUM_PORTS-1:0]               port_en,
  cpm_stream_if.master                       cpm,
  output logic [NUM_PORTS*CNT_W-1:0]         acc_cnt
);

  localparam int SRC_W =
    (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [NUM_PORTS-1:0] eligible;
  logic [NUM_PORTS-1:0] grant;
  logic [SRC_W-1:0]     g;
  logic [SRC_W-1:0]     rr_ptr;
  logic                 any;
  logic                 can_load;
  logic                 accept;
  logic                 valid_q;
  logic [SRC_W-1:0]     src_q;
  cpm_pkt_t             pkt_q;
  cpm_pkt_t             sel;
  logic [CNT_W-1:0]     cnt [NUM_PORTS];

  assign eligible = req_valid & port_en;
  assign can_load = !valid_q || cpm.out_ready;

  cpm_rr_picker #(
    .N (NUM_PORTS),
    .W (SRC_W)
  ) u_picker (
    .eligible (eligible),
    .ptr      (rr_ptr),
    .grant    (grant),
    .idx      (g),
    .any      (any)
  );

  // rst_n gate keeps ready low for the whole reset window
  assign req_ready = (rst_n && can_load && any) ?
                     grant : '0;
  assign accept    = |(req_ready & req_valid);

  always_comb begin
    sel.id      = req_id[g*CPM_ID_W +: CPM_ID_W];
    sel.opcode  = req_opcode[g*CPM_OPC_W +: CPM_OPC_W];
    sel.payload =
      req_payload[g*CPM_PAYLOAD_W +: CPM_PAYLOAD_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pkt_q   <= '0;
      src_q   <= '0;
      rr_ptr  <= '0;
    end else if (accept) begin
      valid_q <= 1'b1;
      pkt_q   <= sel;
      src_q   <= g;
      rr_ptr  <= (g == SRC_W'(NUM_PORTS - 1)) ?
                 '0 : g + 1'b1;
    end else if (cpm.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PORTS; i++)
        cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++)
        if (accept && g == SRC_W'(i))
          cnt[i] <= cnt[i] + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_cnt
    assign acc_cnt[i*CNT_W +: CNT_W] = cnt[i];
  end

  assign cpm.out_valid   = valid_q;
  assign cpm.out_id      = pkt_q.id;
  assign cpm.out_opcode  = pkt_q.opcode;
  assign cpm.out_payload = pkt_q.payload;
  assign cpm.out_src     = src_q;

endmodule
